// File: rtl/ray_setup.sv
// ---------------------------------------------------------------------------
// ray_setup
//
// Per-column ray setup for the wall tracer. On a frame start the six POV
// vectors are captured. For each of the 2^(SHIFT+1) screen columns the block
// produces:
//   - the ray direction,
//   - the DDA delta distances (saturated reciprocals of the ray components),
//   - the step signs,
//   - the player's map cell and fractional position.
// One restoring divider is shared between the X and Y reciprocals.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   i_frame_start              1-cycle pulse: snapshot vectors, restart at col 0
//   playerX/Y                  SQ10.10 player position (non-negative)
//   facingX/Y, vplaneX/Y       SQ10.10 facing and viewplane vectors
//   o_valid / i_ready          result handshake towards the tracer
//   o_col                      column index of the presented result
//   o_rayDirX/Y                SQ10.10 ray direction
//   o_deltaX/Y                 Q10.10 |1/rayDir|, 20'h7FFFF when |rayDir| < 3
//   o_stepX/Y                  1 = ray component negative
//   o_mapX/Y, o_fracX/Y        integer / fractional part of player position
//   o_busy                     high whenever the FSM is not idle
//   o_frame_done               1-cycle pulse after the last column is accepted
// ---------------------------------------------------------------------------
module ray_setup #(
  parameter int SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_frame_start,
  input  logic [19:0]      playerX,
  input  logic [19:0]      playerY,
  input  logic [19:0]      facingX,
  input  logic [19:0]      facingY,
  input  logic [19:0]      vplaneX,
  input  logic [19:0]      vplaneY,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [SHIFT:0]   o_col,
  output logic [19:0]      o_rayDirX,
  output logic [19:0]      o_rayDirY,
  output logic [19:0]      o_deltaX,
  output logic [19:0]      o_deltaY,
  output logic             o_stepX,
  output logic             o_stepY,
  output logic [9:0]       o_mapX,
  output logic [9:0]       o_mapY,
  output logic [9:0]       o_fracX,
  output logic [9:0]       o_fracY,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam int             ACC_W    = 20 + SHIFT;
  localparam logic [SHIFT:0] LAST_COL = '1;
  // The divider consumes one dividend bit per cycle; 2^20 has 21 bits.
  localparam logic [4:0]     DIV_LAST = 5'd20;
  localparam logic [19:0]    SAT_VAL  = 20'h7FFFF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DIVX,
    DIVY,
    OUT
  } state_t;

  state_t state_q;

  // Axis index 0 = X, 1 = Y throughout.
  logic [19:0] player_in [2];
  logic [19:0] facing_in [2];
  logic [19:0] vplane_in [2];

  assign player_in[0] = playerX;
  assign player_in[1] = playerY;
  assign facing_in[0] = facingX;
  assign facing_in[1] = facingY;
  assign vplane_in[0] = vplaneX;
  assign vplane_in[1] = vplaneY;

  // Frame snapshots
  logic [19:0] player_q [2];
  logic [19:0] vplane_q [2];

  // Per-column state and results
  logic signed [ACC_W-1:0] acc_q   [2];
  logic [19:0]             ray_q   [2];
  logic [19:0]             delta_q [2];
  logic [1:0]              step_q;
  logic [SHIFT:0]          col_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    done_q;

  // Derived per-axis values
  logic signed [ACC_W-1:0] acc_init [2];
  logic signed [ACC_W-1:0] acc_next [2];
  logic signed [ACC_W-1:0] acc_shr  [2];
  logic [19:0]             mag      [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    // Left edge of the screen: (facing - vplane), kept with SHIFT extra
    // fraction bits so the per-column vplane step stays exact.
    assign acc_init[gi] = ($signed({{SHIFT{facing_in[gi][19]}}, facing_in[gi]})
                         - $signed({{SHIFT{vplane_in[gi][19]}}, vplane_in[gi]}))
                         <<< SHIFT;
    assign acc_next[gi] = acc_q[gi]
                        + $signed({{SHIFT{vplane_q[gi][19]}}, vplane_q[gi]});
    assign acc_shr[gi]  = acc_q[gi] >>> SHIFT;
    // -2^19 maps to 2^19, which still fits a 20-bit unsigned magnitude.
    assign mag[gi]      = ray_q[gi][19] ? (~ray_q[gi] + 20'd1) : ray_q[gi];
  end

  // -------------------------------------------------------------------------
  // Shared restoring divider: q = floor(2^20 / m), one quotient bit per cycle.
  // The dividend is a single 1 followed by zeros, so the bit shifted into the
  // remainder is 1 only on the first iteration.
  // -------------------------------------------------------------------------
  logic [4:0]  cnt_q;
  logic [19:0] rem_q;
  logic [19:0] quo_q;

  logic [19:0] div_m;
  logic [20:0] div_trial;
  logic [20:0] div_diff;
  logic        div_ge;
  logic [19:0] rem_d;
  logic [19:0] quo_d;
  logic [19:0] div_res;

  always_comb begin
    div_m     = (state_q == DIVY) ? mag[1] : mag[0];
    div_trial = {rem_q, (cnt_q == 5'd0)};
    div_diff  = div_trial - {1'b0, div_m};
    div_ge    = (div_trial >= {1'b0, div_m});
    rem_d     = div_ge ? div_diff[19:0] : div_trial[19:0];
    // For m >= 3 the quotient is below 2^19, so dropping the top bit is safe;
    // m < 3 is saturated anyway.
    quo_d     = {quo_q[18:0], div_ge};
    div_res   = (div_m < 20'd3) ? SAT_VAL : quo_d;
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      for (int k = 0; k < 2; k++) begin
        player_q[k] <= '0;
        vplane_q[k] <= '0;
        acc_q[k]    <= '0;
        ray_q[k]    <= '0;
        delta_q[k]  <= '0;
      end
    end else if (i_frame_start) begin
      // Frame start wins over everything, including a same-cycle handshake.
      state_q <= SETUP;
      col_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        player_q[k] <= player_in[k];
        vplane_q[k] <= vplane_in[k];
        acc_q[k]    <= acc_init[k];
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
        end

        SETUP: begin
          for (int k = 0; k < 2; k++) begin
            ray_q[k]  <= acc_shr[k][19:0];
            step_q[k] <= acc_shr[k][19];
          end
          cnt_q   <= '0;
          rem_q   <= '0;
          quo_q   <= '0;
          state_q <= DIVX;
        end

        DIVX: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == DIV_LAST) begin
            delta_q[0] <= div_res;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            state_q    <= DIVY;
          end
        end

        DIVY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == DIV_LAST) begin
            delta_q[1] <= div_res;
            cnt_q      <= '0;
            valid_q    <= 1'b1;
            state_q    <= OUT;
          end
        end

        OUT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            if (col_q == LAST_COL) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              col_q   <= col_q + 1'b1;
              acc_q   <= acc_next;
              state_q <= SETUP;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_valid      = valid_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_col        = col_q;
  assign o_rayDirX    = ray_q[0];
  assign o_rayDirY    = ray_q[1];
  assign o_deltaX     = delta_q[0];
  assign o_deltaY     = delta_q[1];
  assign o_stepX      = step_q[0];
  assign o_stepY      = step_q[1];
  assign o_mapX       = player_q[0][19:10];
  assign o_mapY       = player_q[1][19:10];
  assign o_fracX      = player_q[0][9:0];
  assign o_fracY      = player_q[1][9:0];

endmodule

// File: tb/tb_ray_setup.sv
// ---------------------------------------------------------------------------
// tb_ray_setup
//
// Directed bench for ray_setup. Player (10.5, 13.25), facing (-1, 0),
// vplane (0, -0.5) gives:
//   rayDirX = -1024 for every column,
//   rayDirY = 512 - 2*col,
// with reciprocals derived by hand from those values.
// ---------------------------------------------------------------------------
module tb_ray_setup;

  logic        clk;
  logic        reset;
  logic        i_frame_start;
  logic [19:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
  logic        o_valid;
  logic        i_ready;
  logic [8:0]  o_col;
  logic [19:0] o_rayDirX, o_rayDirY, o_deltaX, o_deltaY;
  logic        o_stepX, o_stepY;
  logic [9:0]  o_mapX, o_mapY, o_fracX, o_fracY;
  logic        o_busy;
  logic        o_frame_done;

  int checks = 0;
  int errors = 0;
  int n;
  int bad;
  logic done_seen;
  logic [19:0] exp_ry;

  ray_setup #(.SHIFT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_frame_start(i_frame_start),
    .playerX      (playerX),
    .playerY      (playerY),
    .facingX      (facingX),
    .facingY      (facingY),
    .vplaneX      (vplaneX),
    .vplaneY      (vplaneY),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_col        (o_col),
    .o_rayDirX    (o_rayDirX),
    .o_rayDirY    (o_rayDirY),
    .o_deltaX     (o_deltaX),
    .o_deltaY     (o_deltaY),
    .o_stepX      (o_stepX),
    .o_stepY      (o_stepY),
    .o_mapX       (o_mapX),
    .o_mapY       (o_mapY),
    .o_fracX      (o_fracX),
    .o_fracY      (o_fracY),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Caller is at posedge+1; E0 is the next edge.
  task automatic start_frame();
    i_frame_start = 1'b1;
    @(posedge clk);
    #1;
    i_frame_start = 1'b0;
  endtask

  // Counts edges until o_valid is seen (sampled 1 time unit after each edge).
  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
      if (o_frame_done) done_seen = 1'b1;
    end while (!o_valid && cnt < 200);
    if (!o_valid) check("valid_timeout", {31'b0, o_valid}, 32'd1);
  endtask

  task automatic set_frame1();
    playerX = 20'd10752;   // 10.5
    playerY = 20'd13568;   // 13.25
    facingX = 20'hFFC00;   // -1.0
    facingY = 20'd0;
    vplaneX = 20'd0;
    vplaneY = 20'hFFE00;   // -0.5
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    i_frame_start = 1'b0;
    i_ready = 1'b0;
    done_seen = 1'b0;
    set_frame1();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_done", {31'b0, o_frame_done}, 32'd0);
    check("rst_col", {23'b0, o_col}, 32'd0);
    check("rst_rayx", {12'b0, o_rayDirX}, 32'd0);
    check("rst_deltay", {12'b0, o_deltaY}, 32'd0);
    check("rst_mapx", {22'b0, o_mapX}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ---- Asynchronous reset while dividing X ----
    start_frame();
    repeat (5) begin @(posedge clk); #1; end
    check("divx_busy", {31'b0, o_busy}, 32'd1);
    check("divx_rayx", {12'b0, o_rayDirX}, 32'hFFC00);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {31'b0, o_busy}, 32'd0);
    check("arst_rayx", {12'b0, o_rayDirX}, 32'd0);
    check("arst_stepx", {31'b0, o_stepX}, 32'd0);
    check("arst_mapx", {22'b0, o_mapX}, 32'd0);
    check("arst_fracx", {22'b0, o_fracX}, 32'd0);
    #2 reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("idle_busy", {31'b0, o_busy}, 32'd0);
    check("idle_valid", {31'b0, o_valid}, 32'd0);

    // ---- Column 0 latency and values, then backpressure ----
    start_frame();
    repeat (42) begin @(posedge clk); #1; end
    check("col0_not_yet", {31'b0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("col0_valid", {31'b0, o_valid}, 32'd1);
    check("col0_col", {23'b0, o_col}, 32'd0);
    check("col0_rayx", {12'b0, o_rayDirX}, 32'hFFC00);
    check("col0_rayy", {12'b0, o_rayDirY}, 32'd512);
    check("col0_deltax", {12'b0, o_deltaX}, 32'd1024);
    check("col0_deltay", {12'b0, o_deltaY}, 32'd2048);
    check("col0_stepx", {31'b0, o_stepX}, 32'd1);
    check("col0_stepy", {31'b0, o_stepY}, 32'd0);
    check("col0_mapx", {22'b0, o_mapX}, 32'd10);
    check("col0_mapy", {22'b0, o_mapY}, 32'd13);
    check("col0_fracx", {22'b0, o_fracX}, 32'd512);
    check("col0_fracy", {22'b0, o_fracY}, 32'd256);
    $display("col 0 rayDir %05h %05h delta %05h %05h", o_rayDirX, o_rayDirY, o_deltaX, o_deltaY);

    bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (o_valid !== 1'b1 || o_col !== 9'd0 || o_rayDirX !== 20'hFFC00 ||
          o_rayDirY !== 20'd512 || o_deltaX !== 20'd1024 || o_deltaY !== 20'd2048 ||
          o_stepX !== 1'b1 || o_stepY !== 1'b0 || o_mapX !== 10'd10)
        bad++;
    end
    check("bp_unstable_cycles", bad, 32'd0);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_accept_valid", {31'b0, o_valid}, 32'd0);
    check("bp_accept_col", {23'b0, o_col}, 32'd1);

    // ---- Remaining columns with i_ready held high ----
    for (int c = 1; c < 512; c++) begin
      wait_valid(n);
      if (c == 1) check("lat_after_hs", n, 32'd43);
      if (c == 2) check("col_period", n, 32'd44);
      exp_ry = 20'(512 - 2 * c);
      check("col_idx", {23'b0, o_col}, c);
      check("col_rayx", {12'b0, o_rayDirX}, 32'hFFC00);
      check("col_rayy", {12'b0, o_rayDirY}, {12'b0, exp_ry});
      $display("col %0d rayDir %05h %05h delta %05h %05h", o_col, o_rayDirX, o_rayDirY, o_deltaX, o_deltaY);
      if (c == 100) begin
        // New vectors mid-frame must not leak into this frame.
        facingX = 20'd2048;
        facingY = 20'd1024;
        vplaneY = 20'd0;
        playerX = 20'd0;
      end
      if (c == 256) begin
        check("c256_rayy", {12'b0, o_rayDirY}, 32'd0);
        check("c256_deltay", {12'b0, o_deltaY}, 32'h7FFFF);
        check("c256_deltax", {12'b0, o_deltaX}, 32'd1024);
      end
      if (c == 511) begin
        check("c511_rayy", {12'b0, o_rayDirY}, 32'hFFE02);
        check("c511_deltay", {12'b0, o_deltaY}, 32'd2056);
        check("c511_stepy", {31'b0, o_stepY}, 32'd1);
        check("c511_mapx", {22'b0, o_mapX}, 32'd10);
      end
    end
    check("no_early_done", {31'b0, done_seen}, 32'd0);
    @(posedge clk);
    #1;
    check("last_done", {31'b0, o_frame_done}, 32'd1);
    check("last_busy", {31'b0, o_busy}, 32'd0);
    check("last_valid", {31'b0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'b0, o_frame_done}, 32'd0);

    // ---- Abort coinciding with a handshake at column 37 ----
    set_frame1();
    start_frame();
    done_seen = 1'b0;
    for (int c = 0; c <= 37; c++) wait_valid(n);
    check("pre_abort_col", {23'b0, o_col}, 32'd37);
    check("pre_abort_rayy", {12'b0, o_rayDirY}, 32'd438);
    i_frame_start = 1'b1;
    vplaneY = 20'hFFC00;   // -1.0
    @(posedge clk);
    #1;
    i_frame_start = 1'b0;
    if (o_frame_done) done_seen = 1'b1;
    check("abort_valid", {31'b0, o_valid}, 32'd0);
    check("abort_col", {23'b0, o_col}, 32'd0);
    check("abort_busy", {31'b0, o_busy}, 32'd1);
    wait_valid(n);
    check("abort_lat", n, 32'd43);
    check("abort_col0", {23'b0, o_col}, 32'd0);
    check("abort_rayx", {12'b0, o_rayDirX}, 32'hFFC00);
    check("abort_rayy", {12'b0, o_rayDirY}, 32'd1024);
    check("abort_deltay", {12'b0, o_deltaY}, 32'd1024);
    check("abort_no_done", {31'b0, done_seen}, 32'd0);
    $display("abort col %0d rayDir %05h %05h delta %05h %05h", o_col, o_rayDirX, o_rayDirY, o_deltaX, o_deltaY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
